// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - prefetching instruction fetch unit with redirect flush
//
// Purpose: issues sequential instruction fetches ahead of decode and keeps
// the returned words in an in-order prefetch buffer. Ecall and branch
// redirects flush the buffer and discard the responses still in flight.
// A misaligned redirect target parks the unit in FAULT until the next
// redirect arrives.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   ecall_taken/ecall_target    redirect request, highest priority
//   branch_taken/branch_target  redirect request, used when no ecall
//   req_valid/req_ready/req_addr  fetch request channel to memory
//   resp_valid/resp_data        in-order memory response, always accepted
//   inst_valid/inst_ready       head-of-buffer handshake to decode
//   inst, pc, snpc              head instruction, its PC and PC + 4
//   fetch_fault, fault_pc       misaligned redirect target is held
//
// Optional build macro IFU_PREFETCH_PERF_EN adds the perf_fetched,
// perf_flushed and perf_stall event counters.

module ifu_prefetch #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
   parameter int              BUF_DEPTH = 4,
   parameter int              CNT_W     = $clog2(BUF_DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ecall_taken,
   input  logic [XLEN-1:0] ecall_target,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   input  logic            resp_valid,
   input  logic [XLEN-1:0] resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] snpc,
   output logic            fetch_fault,
   output logic [XLEN-1:0] fault_pc
`ifdef IFU_PREFETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_flushed,
   output logic [31:0]     perf_stall
`endif
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam logic [CNT_W:0]   DEPTH_W = (CNT_W+1)'(BUF_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  fault_pc_q, fault_pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] pf_rd_q, pf_rd_d;
   logic [PTR_W-1:0] pf_wr_q, pf_wr_d;

   // Instruction buffer and the side FIFO holding the PC of every live
   // (not yet dropped) request in issue order.
   logic [XLEN-1:0]  buf_inst_q [BUF_DEPTH];
   logic [XLEN-1:0]  buf_pc_q   [BUF_DEPTH];
   logic [XLEN-1:0]  pf_pc_q    [BUF_DEPTH];

   logic            redirect;
   logic [XLEN-1:0] target;
   logic [CNT_W:0]  live_cnt;
   logic            req_fire;
   logic            resp_ok;
   logic            resp_live;
   logic            resp_drop;
   logic            pop;

   assign redirect = ecall_taken | branch_taken;
   assign target   = ecall_taken ? ecall_target : branch_target;

   // Buffered entries plus requests whose data will still be kept; the
   // dropped responses no longer need a buffer slot.
   assign live_cnt = {1'b0, count_q} + {1'b0, outstanding_q} - {1'b0, drop_q};

   assign req_valid = (state_q == ST_RUN) && !redirect && (live_cnt < DEPTH_W);
   assign req_addr  = fetch_pc_q;
   assign req_fire  = req_valid & req_ready;

   // Guarding on outstanding keeps the counters from underflowing when a
   // spurious response shows up.
   assign resp_ok   = resp_valid && (outstanding_q != '0);
   assign resp_live = resp_ok && !redirect && (drop_q == '0);
   assign resp_drop = resp_ok && !redirect && (drop_q != '0);

   assign inst_valid = (count_q != '0);
   assign pop        = inst_valid & inst_ready & !redirect;

   assign inst        = inst_valid ? buf_inst_q[rd_ptr_q] : '0;
   assign pc          = inst_valid ? buf_pc_q[rd_ptr_q] : RESET_PC;
   assign snpc        = pc + XLEN'(4);
   assign fetch_fault = (state_q == ST_FAULT);
   assign fault_pc    = fault_pc_q;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      fault_pc_d    = fault_pc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      pf_rd_d       = pf_rd_q;
      pf_wr_d       = pf_wr_q;

      if (redirect) begin
         // Everything issued so far becomes stale; the response arriving
         // in this cycle is already discarded, so it is not counted again.
         count_d       = '0;
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
         pf_rd_d       = '0;
         pf_wr_d       = '0;
         outstanding_d = outstanding_q - CNT_W'(resp_ok);
         drop_d        = outstanding_q - CNT_W'(resp_ok);
         fetch_pc_d    = target;
         if (target[1:0] != 2'b00) begin
            state_d    = ST_FAULT;
            fault_pc_d = target;
         end else begin
            state_d    = ST_RUN;
         end
      end else begin
         if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
         end
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            pf_wr_d    = pf_wr_q + PTR_W'(1);
         end
         outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_ok);
         drop_d        = drop_q - CNT_W'(resp_drop);
         if (resp_live) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            pf_rd_d  = pf_rd_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(resp_live) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_BOOT;
         fetch_pc_q    <= RESET_PC;
         fault_pc_q    <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         pf_rd_q       <= '0;
         pf_wr_q       <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         fault_pc_q    <= fault_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         pf_rd_q       <= pf_rd_d;
         pf_wr_q       <= pf_wr_d;
      end
   end

   // Storage needs no reset: every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         pf_pc_q[pf_wr_q] <= fetch_pc_q;
      end
      if (resp_live) begin
         buf_inst_q[wr_ptr_q] <= resp_data;
         buf_pc_q[wr_ptr_q]   <= pf_pc_q[pf_rd_q];
      end
   end

`ifdef IFU_PREFETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_flushed_q, perf_flushed_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q + 32'(pop);
      perf_flushed_d = perf_flushed_q;
      if (redirect) begin
         perf_flushed_d = perf_flushed_q + 32'(live_cnt);
      end
      perf_stall_d = perf_stall_q;
      if (inst_ready && !inst_valid && (state_q != ST_FAULT)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_flushed_q <= perf_flushed_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
   assign perf_stall   = perf_stall_q;
`endif

   // Protocol checks: responses must match a request, the credit rule must
   // keep the buffer from overflowing, and the in-flight counter must fit.
   always @(posedge clk) begin
      if (rst) begin
         assert (!(resp_valid && (outstanding_q == '0)));
         assert (!(resp_live && (count_q == DEPTH_C)));
         assert (!(req_fire && !resp_ok && (outstanding_q == {CNT_W{1'b1}})));
      end
   end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - scoreboard testbench for ifu_prefetch

module tb_ifu_prefetch;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic        ecall_taken;
   logic [31:0] ecall_target;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] snpc;
   logic        fetch_fault;
   logic [31:0] fault_pc;

   ifu_prefetch dut (
      .clk           (clk),
      .rst           (rst),
      .ecall_taken   (ecall_taken),
      .ecall_target  (ecall_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst          (inst),
      .pc            (pc),
      .snpc          (snpc),
      .fetch_fault   (fetch_fault),
      .fault_pc      (fault_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int n_req  = 0;
   bit mem_stall = 1'b0;

   logic [31:0] mem_q [$];
   logic [31:0] exp_q [$];
   logic [31:0] req_log [$];
   logic [31:0] pop_log [$];

   logic        s_req_valid;
   logic [31:0] s_req_addr;
   logic        s_inst_valid;
   logic [31:0] s_pc;
   logic [31:0] s_snpc;
   logic        s_fetch_fault;
   logic [31:0] s_fault_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   // One clock cycle: sample mid-cycle, run the scoreboard, then drive the
   // next cycle's memory response (1-cycle latency unless stalled).
   task automatic tick();
      logic        redir;
      logic [31:0] e;
      @(negedge clk);
      redir         = ecall_taken | branch_taken;
      s_req_valid   = req_valid;
      s_req_addr    = req_addr;
      s_inst_valid  = inst_valid;
      s_pc          = pc;
      s_snpc        = snpc;
      s_fetch_fault = fetch_fault;
      s_fault_pc    = fault_pc;
      if (redir) exp_q.delete();
      if (req_valid && req_ready) begin
         mem_q.push_back(req_addr);
         exp_q.push_back(req_addr);
         req_log.push_back(req_addr);
         n_req++;
      end
      if (inst_valid && inst_ready && !redir) begin
         pop_log.push_back(pc);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got pc=%h inst=%h, nothing expected", pc, inst);
         end else begin
            e = exp_q.pop_front();
            if (pc !== e || inst !== mem_word(e) || snpc !== e + 32'd4) begin
               errors++;
               $display("FAIL sb_pop got pc=%h inst=%h snpc=%h expected pc=%h inst=%h snpc=%h",
                        pc, inst, snpc, e, mem_word(e), e + 32'd4);
            end
         end
      end
      @(posedge clk);
      #1;
      ecall_taken  = 1'b0;
      branch_taken = 1'b0;
      if (!mem_stall && mem_q.size() > 0) begin
         resp_valid = 1'b1;
         resp_data  = mem_word(mem_q.pop_front());
      end else begin
         resp_valid = 1'b0;
         resp_data  = '0;
      end
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      ecall_taken  = 1'b0;
      branch_taken = 1'b0;
      resp_valid   = 1'b0;
      resp_data    = '0;
      mem_q.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 7;
      if (req_valid !== 1'b0)   begin errors++; $display("FAIL rst_req_valid got %b want 0", req_valid); end
      if (inst_valid !== 1'b0)  begin errors++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
      if (inst !== 32'h0)       begin errors++; $display("FAIL rst_inst got %h want 0", inst); end
      if (pc !== RESET_PC)      begin errors++; $display("FAIL rst_pc got %h want %h", pc, RESET_PC); end
      if (snpc !== RESET_PC + 32'd4) begin errors++; $display("FAIL rst_snpc got %h want %h", snpc, RESET_PC + 32'd4); end
      if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", fetch_fault); end
      if (fault_pc !== 32'h0)   begin errors++; $display("FAIL rst_fault_pc got %h want 0", fault_pc); end
   endtask

   task automatic test_sequential();
      logic exp_iv;
      inst_ready = 1'b1;
      req_ready  = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (i == 0) begin
            if (s_req_valid !== 1'b0) begin errors++; $display("FAIL seq_boot_req cycle %0d got %b want 0", i, s_req_valid); end
         end else if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC + 32'(4 * (i - 1))) begin
            errors++;
            $display("FAIL seq_req cycle %0d got v=%b addr=%h want v=1 addr=%h", i, s_req_valid, s_req_addr, RESET_PC + 32'(4 * (i - 1)));
         end
         exp_iv = (i >= 3);
         checks++;
         if (s_inst_valid !== exp_iv) begin errors++; $display("FAIL seq_inst_valid cycle %0d got %b want %b", i, s_inst_valid, exp_iv); end
         if (i == 3) begin
            checks += 2;
            if (s_pc !== RESET_PC) begin errors++; $display("FAIL seq_first_pc got %h want %h", s_pc, RESET_PC); end
            if (s_snpc !== RESET_PC + 32'd4) begin errors++; $display("FAIL seq_first_snpc got %h want %h", s_snpc, RESET_PC + 32'd4); end
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      int pl;
      inst_ready = 1'b0;
      do_reset();
      base = n_req;
      repeat (12) tick();
      checks += 3;
      if (n_req - base != 4) begin errors++; $display("FAIL bp_req_count got %0d want 4", n_req - base); end
      if (s_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stop got %b want 0", s_req_valid); end
      if (s_inst_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid got %b want 1", s_inst_valid); end
      inst_ready = 1'b1;
      pl = pop_log.size();
      repeat (10) tick();
      checks++;
      if (pop_log.size() < pl + 4) begin
         errors++;
         $display("FAIL bp_pop_count got %0d want >=4", pop_log.size() - pl);
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (pop_log[pl + k] !== RESET_PC + 32'(4 * k)) begin
               errors++;
               $display("FAIL bp_pop_order index %0d got %h want %h", k, pop_log[pl + k], RESET_PC + 32'(4 * k));
            end
         end
      end
      checks++;
      if (n_req - base <= 4) begin errors++; $display("FAIL bp_resume got %0d requests want >4", n_req - base); end
   endtask

   task automatic test_branch_flush();
      int base;
      int pl;
      inst_ready = 1'b1;
      mem_stall  = 1'b1;
      do_reset();
      base = n_req;
      for (int k = 0; k < 20 && (n_req - base) < 3; k++) tick();
      checks++;
      if (n_req - base != 3) begin errors++; $display("FAIL br_inflight got %0d want 3", n_req - base); end
      pl = pop_log.size();
      branch_taken  = 1'b1;
      branch_target = 32'h8000_0100;
      mem_stall     = 1'b0;
      tick();
      repeat (10) tick();
      checks++;
      if (pop_log.size() <= pl) begin
         errors++;
         $display("FAIL br_no_pop got 0 pops want >0");
      end else if (pop_log[pl] !== 32'h8000_0100) begin
         errors++;
         $display("FAIL br_first_pc got %h want 80000100", pop_log[pl]);
      end
   endtask

   task automatic test_ecall_priority();
      int rl;
      int pl;
      rl = req_log.size();
      pl = pop_log.size();
      ecall_taken   = 1'b1;
      ecall_target  = 32'h8000_0200;
      branch_taken  = 1'b1;
      branch_target = 32'h8000_0300;
      tick();
      repeat (6) tick();
      checks += 2;
      if (req_log.size() <= rl || req_log[rl] !== 32'h8000_0200) begin
         errors++;
         $display("FAIL prio_req got %h want 80000200", (req_log.size() > rl) ? req_log[rl] : 32'hx);
      end
      if (pop_log.size() <= pl || pop_log[pl] !== 32'h8000_0200) begin
         errors++;
         $display("FAIL prio_pop got %h want 80000200", (pop_log.size() > pl) ? pop_log[pl] : 32'hx);
      end
   endtask

   task automatic test_fault();
      int rl;
      int pl;
      rl = req_log.size();
      pl = pop_log.size();
      branch_taken  = 1'b1;
      branch_target = 32'h8000_0102;
      tick();
      tick();
      checks += 4;
      if (s_fetch_fault !== 1'b1) begin errors++; $display("FAIL flt_flag got %b want 1", s_fetch_fault); end
      if (s_fault_pc !== 32'h8000_0102) begin errors++; $display("FAIL flt_pc got %h want 80000102", s_fault_pc); end
      if (s_req_valid !== 1'b0) begin errors++; $display("FAIL flt_req got %b want 0", s_req_valid); end
      if (s_inst_valid !== 1'b0) begin errors++; $display("FAIL flt_inst_valid got %b want 0", s_inst_valid); end
      repeat (3) tick();
      checks += 2;
      if (req_log.size() != rl) begin errors++; $display("FAIL flt_no_req got %0d want 0", req_log.size() - rl); end
      if (pop_log.size() != pl) begin errors++; $display("FAIL flt_no_pop got %0d want 0", pop_log.size() - pl); end
      ecall_taken  = 1'b1;
      ecall_target = 32'h8000_0400;
      tick();
      tick();
      checks++;
      if (s_fetch_fault !== 1'b0) begin errors++; $display("FAIL flt_clear got %b want 0", s_fetch_fault); end
      repeat (5) tick();
      checks += 2;
      if (req_log.size() <= rl || req_log[rl] !== 32'h8000_0400) begin
         errors++;
         $display("FAIL flt_resume_req got %h want 80000400", (req_log.size() > rl) ? req_log[rl] : 32'hx);
      end
      if (pop_log.size() <= pl || pop_log[pl] !== 32'h8000_0400) begin
         errors++;
         $display("FAIL flt_resume_pop got %h want 80000400", (pop_log.size() > pl) ? pop_log[pl] : 32'hx);
      end
   endtask

   task automatic test_reset_midstream();
      int base;
      int rl;
      int pl;
      branch_taken  = 1'b1;
      branch_target = 32'h8000_0702;
      tick();
      repeat (3) tick();
      mem_stall    = 1'b1;
      ecall_taken  = 1'b1;
      ecall_target = 32'h8000_0800;
      base = n_req;
      repeat (3) tick();
      checks++;
      if (n_req - base != 2) begin errors++; $display("FAIL mid_inflight got %0d want 2", n_req - base); end
      rst = 1'b0;
      #1;
      checks += 7;
      if (req_valid !== 1'b0)   begin errors++; $display("FAIL mid_req_valid got %b want 0", req_valid); end
      if (inst_valid !== 1'b0)  begin errors++; $display("FAIL mid_inst_valid got %b want 0", inst_valid); end
      if (inst !== 32'h0)       begin errors++; $display("FAIL mid_inst got %h want 0", inst); end
      if (pc !== RESET_PC)      begin errors++; $display("FAIL mid_pc got %h want %h", pc, RESET_PC); end
      if (snpc !== RESET_PC + 32'd4) begin errors++; $display("FAIL mid_snpc got %h want %h", snpc, RESET_PC + 32'd4); end
      if (fetch_fault !== 1'b0) begin errors++; $display("FAIL mid_fault got %b want 0", fetch_fault); end
      if (fault_pc !== 32'h0)   begin errors++; $display("FAIL mid_fault_pc got %h want 0", fault_pc); end
      mem_q.delete();
      exp_q.delete();
      resp_valid = 1'b0;
      resp_data  = '0;
      mem_stall  = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      rl = req_log.size();
      pl = pop_log.size();
      tick();
      checks++;
      if (s_req_valid !== 1'b0) begin errors++; $display("FAIL mid_boot_req got %b want 0", s_req_valid); end
      repeat (7) tick();
      checks += 2;
      if (req_log.size() <= rl || req_log[rl] !== RESET_PC) begin
         errors++;
         $display("FAIL mid_restart_req got %h want %h", (req_log.size() > rl) ? req_log[rl] : 32'hx, RESET_PC);
      end
      if (pop_log.size() <= pl || pop_log[pl] !== RESET_PC) begin
         errors++;
         $display("FAIL mid_restart_pop got %h want %h", (pop_log.size() > pl) ? pop_log[pl] : 32'hx, RESET_PC);
      end
   endtask

   initial begin
      rst           = 1'b1;
      ecall_taken   = 1'b0;
      ecall_target  = '0;
      branch_taken  = 1'b0;
      branch_target = '0;
      req_ready     = 1'b1;
      resp_valid    = 1'b0;
      resp_data     = '0;
      inst_ready    = 1'b0;
      #3 rst = 1'b0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_branch_flush();
      test_ecall_priority();
      test_fault();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
